// File: rtl/vote_result_reader_if.sv
// Readout stream between the vote result reader and the display/host side.
// Master presents beats with out_valid; slave accepts them with out_ready.
interface vote_result_reader_if #(
  parameter int WIDTH = 8
);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_cand;
  logic             out_last;

  modport master (
    output out_valid, out_data, out_cand, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_cand, out_last,
    output out_ready
  );
endinterface

// File: rtl/vote_result_reader.sv
// Snapshots four candidate tallies on request and streams them out one beat per cycle,
// tracking the winner (lowest index on ties) and a tie flag; stalls hold the beat, mode=0 aborts.
module vote_result_reader #(
  parameter int WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 mode,
  input  logic                 read_req,
  input  logic [WIDTH-1:0]     cand_vote_recvd0,
  input  logic [WIDTH-1:0]     cand_vote_recvd1,
  input  logic [WIDTH-1:0]     cand_vote_recvd2,
  input  logic [WIDTH-1:0]     cand_vote_recvd3,
  vote_result_reader_if.master out_if,
  output logic                 busy,
  output logic [1:0]           winner,
  output logic                 tie,
  output logic                 winner_valid
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] snap_q [4];
  logic [WIDTH-1:0] snap_d [4];
  logic [1:0]       beat_q, beat_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [1:0]       win_q, win_d;
  logic             tie_r_q, tie_r_d;
  logic [1:0]       winner_q, winner_d;
  logic             tie_q, tie_d;
  logic             wv_q, wv_d;

  logic [WIDTH-1:0] cur_data;
  logic             send_vld;
  logic [WIDTH-1:0] upd_max;
  logic [1:0]       upd_win;
  logic             upd_tie;

  assign send_vld = (state_q == SEND);
  assign cur_data = snap_q[beat_q];

  // Beat 0 seeds the running max unconditionally so an all-zero first tally is not a tie.
  always_comb begin
    upd_max = max_q;
    upd_win = win_q;
    upd_tie = tie_r_q;
    if ((beat_q == 2'd0) || (cur_data > max_q)) begin
      upd_max = cur_data;
      upd_win = beat_q;
      upd_tie = 1'b0;
    end else if (cur_data == max_q) begin
      upd_tie = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    beat_d   = beat_q;
    max_d    = max_q;
    win_d    = win_q;
    tie_r_d  = tie_r_q;
    winner_d = winner_q;
    tie_d    = tie_q;
    wv_d     = wv_q;
    case (state_q)
      IDLE: begin
        if (mode && read_req) begin
          snap_d[0] = cand_vote_recvd0;
          snap_d[1] = cand_vote_recvd1;
          snap_d[2] = cand_vote_recvd2;
          snap_d[3] = cand_vote_recvd3;
          beat_d    = 2'd0;
          max_d     = '0;
          win_d     = 2'd0;
          tie_r_d   = 1'b0;
          winner_d  = 2'd0;
          tie_d     = 1'b0;
          wv_d      = 1'b0;
          state_d   = SEND;
        end else if (!mode) begin
          wv_d = 1'b0;
        end
      end
      SEND: begin
        if (!mode) begin
          wv_d    = 1'b0;
          state_d = IDLE;
        end else if (out_if.out_ready) begin
          max_d   = upd_max;
          win_d   = upd_win;
          tie_r_d = upd_tie;
          if (beat_q == 2'd3) begin
            winner_d = upd_win;
            tie_d    = upd_tie;
            wv_d     = 1'b1;
            state_d  = IDLE;
          end else begin
            beat_d = beat_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      snap_q   <= '{default: '0};
      beat_q   <= 2'd0;
      max_q    <= '0;
      win_q    <= 2'd0;
      tie_r_q  <= 1'b0;
      winner_q <= 2'd0;
      tie_q    <= 1'b0;
      wv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      snap_q   <= snap_d;
      beat_q   <= beat_d;
      max_q    <= max_d;
      win_q    <= win_d;
      tie_r_q  <= tie_r_d;
      winner_q <= winner_d;
      tie_q    <= tie_d;
      wv_q     <= wv_d;
    end
  end

  assign out_if.out_valid = send_vld;
  assign out_if.out_data  = send_vld ? cur_data : '0;
  assign out_if.out_cand  = send_vld ? beat_q : 2'd0;
  assign out_if.out_last  = send_vld && (beat_q == 2'd3);
  assign busy             = send_vld;
  assign winner           = winner_q;
  assign tie              = tie_q;
  assign winner_valid     = wv_q;

endmodule

// File: tb/tb_vote_result_reader.sv
// Directed bench for vote_result_reader: streams, stalls, snapshot isolation, abort, extremes, async reset.
module tb_vote_result_reader;

  logic       clk;
  logic       rst_n;
  logic       mode;
  logic       read_req;
  logic [7:0] t0, t1, t2, t3;
  logic       busy;
  logic [1:0] winner;
  logic       tie;
  logic       winner_valid;

  int total;
  int bad;

  vote_result_reader_if #(.WIDTH(8)) bus ();

  vote_result_reader #(.WIDTH(8)) dut (
    .clock            (clk),
    .reset            (rst_n),
    .mode             (mode),
    .read_req         (read_req),
    .cand_vote_recvd0 (t0),
    .cand_vote_recvd1 (t1),
    .cand_vote_recvd2 (t2),
    .cand_vote_recvd3 (t3),
    .out_if           (bus.master),
    .busy             (busy),
    .winner           (winner),
    .tie              (tie),
    .winner_valid     (winner_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_tallies(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d);
    t0 = a; t1 = b; t2 = c; t3 = d;
  endtask

  // Called at a negedge with tallies already set; returns at the negedge after completion.
  task automatic stream(input logic [31:0] exp_pk, input int stall_beat, input int stall_n,
                        input bit mutate, input logic [1:0] ew, input logic et);
    logic [7:0] e;
    read_req = 1'b1;
    @(negedge clk);
    read_req = 1'b0;
    for (int b = 0; b < 4; b++) begin
      e = exp_pk[8*b +: 8];
      if (b == stall_beat) begin
        bus.out_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          chk($sformatf("stall_vld_b%0d_s%0d", b, s), bus.out_valid, 1);
          chk($sformatf("stall_cand_b%0d_s%0d", b, s), bus.out_cand, b);
          chk($sformatf("stall_data_b%0d_s%0d", b, s), bus.out_data, e);
          @(negedge clk);
        end
        bus.out_ready = 1'b1;
      end
      chk($sformatf("vld_b%0d", b), bus.out_valid, 1);
      chk($sformatf("cand_b%0d", b), bus.out_cand, b);
      chk($sformatf("data_b%0d", b), bus.out_data, e);
      chk($sformatf("last_b%0d", b), bus.out_last, (b == 3) ? 1 : 0);
      chk($sformatf("busy_b%0d", b), busy, 1);
      if (mutate && b == 0) set_tallies(8'hFF, 8'hFF, 8'hFF, 8'hFF);
      @(negedge clk);
    end
    chk("end_vld", bus.out_valid, 0);
    chk("end_busy", busy, 0);
    chk("end_last", bus.out_last, 0);
    chk("winner", winner, ew);
    chk("tie", tie, et);
    chk("winner_valid", winner_valid, 1);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    mode = 1'b0;
    read_req = 1'b0;
    bus.out_ready = 1'b1;
    set_tallies(8'd0, 8'd0, 8'd0, 8'd0);
    repeat (2) @(negedge clk);
    chk("rst_vld", bus.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wv", winner_valid, 0);
    chk("rst_winner", winner, 0);
    chk("rst_tie", tie, 0);
    rst_n = 1'b1;
    mode = 1'b1;
    @(negedge clk);

    // Two-way tie between candidates 1 and 2: lowest index wins.
    set_tallies(8'd5, 8'd9, 8'd9, 8'd2);
    stream({8'd2, 8'd9, 8'd9, 8'd5}, -1, 0, 1'b0, 2'd1, 1'b1);

    // Stall on beat 2 for three cycles.
    set_tallies(8'd3, 8'd7, 8'd1, 8'd200);
    stream({8'd200, 8'd1, 8'd7, 8'd3}, 2, 3, 1'b0, 2'd3, 1'b0);

    // Live tallies change after beat 0; snapshot must be streamed.
    set_tallies(8'd10, 8'd20, 8'd30, 8'd40);
    stream({8'd40, 8'd30, 8'd20, 8'd10}, -1, 0, 1'b1, 2'd3, 1'b0);

    // Abort after beat 1 transfers.
    set_tallies(8'd1, 8'd2, 8'd3, 8'd4);
    read_req = 1'b1;
    @(negedge clk);
    read_req = 1'b0;
    chk("ab_wv_cleared", winner_valid, 0);
    @(negedge clk);
    @(negedge clk);
    chk("ab_cand2", bus.out_cand, 2);
    mode = 1'b0;
    @(negedge clk);
    chk("ab_vld", bus.out_valid, 0);
    chk("ab_busy", busy, 0);
    chk("ab_wv", winner_valid, 0);
    read_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("m0_req_vld", bus.out_valid, 0);
    chk("m0_req_busy", busy, 0);
    read_req = 1'b0;
    mode = 1'b1;
    @(negedge clk);

    // Extremes: all zero and all full scale.
    set_tallies(8'd0, 8'd0, 8'd0, 8'd0);
    stream(32'h0000_0000, -1, 0, 1'b0, 2'd0, 1'b1);
    set_tallies(8'd255, 8'd255, 8'd255, 8'd255);
    stream(32'hFFFF_FFFF, -1, 0, 1'b0, 2'd0, 1'b1);

    // mode=0 in IDLE clears a held result.
    mode = 1'b0;
    @(negedge clk);
    chk("m0_idle_wv", winner_valid, 0);
    mode = 1'b1;
    @(negedge clk);

    // Async reset mid-stream, between clock edges.
    set_tallies(8'd4, 8'd3, 8'd2, 8'd1);
    read_req = 1'b1;
    @(negedge clk);
    read_req = 1'b0;
    @(negedge clk);
    chk("pre_rst_vld", bus.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld", bus.out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_data", bus.out_data, 0);
    chk("arst_cand", bus.out_cand, 0);
    chk("arst_last", bus.out_last, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    stream({8'd1, 8'd2, 8'd3, 8'd4}, -1, 0, 1'b0, 2'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vote_result_reader.md
Name: vote_result_reader

Overview:
- Read-side companion to the vote counter: in result mode (mode=1), on request, snapshots the four candidate tallies and streams them out one per beat over a valid/ready interface.
- Computes the winning candidate and a tie flag as the stream proceeds.
- Sits between the tally registers and the display/host readout logic.

Parameters:
WIDTH, 8, bit width of each tally and of out_data

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
mode  input  1  0 = voting mode, 1 = result mode
read_req  input  1  request to start a readout; honoured only when idle and mode=1
cand_vote_recvd0..3  input  WIDTH each  live tallies for candidates 0..3
out_ready  input  1  downstream accepts the current beat
out_valid  output  1  out_data/out_cand/out_last are valid
out_data  output  WIDTH  snapshot tally for out_cand
out_cand  output  2  candidate index of the current beat
out_last  output  1  high on the candidate-3 beat
busy  output  1  high in SEND
winner  output  2  index of the highest tally
tie  output  1  another candidate equals the winning tally
winner_valid  output  1  winner/tie hold the result of a completed readout

Behaviour:
- Reset (reset=0, asynchronous) sets every output and internal register to 0, including out_valid, out_data, out_cand, out_last, busy, winner, tie, winner_valid and the snapshot registers. The FSM goes to IDLE.
- FSM states are IDLE and SEND.
- IDLE -> SEND when read_req=1 and mode=1 at a rising edge. At that edge:
  - all four tallies are captured into snapshot registers;
  - beat index is set to 0;
  - winner_valid, winner and tie are cleared;
  - running max is set to 0.
- Latency: out_valid=1, out_cand=0 and out_data=snapshot0 appear in the cycle after the request edge.
- read_req is ignored in SEND, and ignored whenever mode=0.
- Handshake: a beat transfers at a rising edge with out_valid=1 and out_ready=1.
  - While out_ready=0, out_valid, out_data, out_cand and out_last hold steady.
  - After a non-last transfer, the next beat is presented in the following cycle, with out_valid staying high. Throughput is 1 beat/cycle with out_ready tied high.
- Beat order is 0,1,2,3; out_last=1 only when out_cand=3.
- Winner tracking, applied on each transfer with data d and index i:
  - if d > max: max=d, win=i, tie_r=0;
  - else if d == max: tie_r=1, win unchanged (lowest index wins ties).
  - Beat 0 always sets max=d and win=0, even when d=0.
  - Comparison is unsigned WIDTH-bit; there is no arithmetic, so no wrap concerns.
- On the last-beat transfer (registered at that edge):
  - winner=win and tie=tie_r, with beat 3 included;
  - winner_valid=1;
  - out_valid=0, busy=0, FSM goes to IDLE.
- winner_valid stays high until the next accepted read_req, mode=0 sampled at an edge, or reset.
- Snapshot isolation: changes on cand_vote_recvd* during SEND do not affect streamed data.
- Abort: mode=0 sampled at any edge while in SEND returns the FSM to IDLE.
  - Next cycle: out_valid=0, busy=0, winner_valid=0.
  - This is the only case where out_valid drops without a transfer.
- Reset mid-stream: all outputs drop to 0 immediately, without waiting for the clock edge.
- busy=1 exactly while in SEND.

Test Plan:
- Tallies 5,9,9,2, mode=1, one-cycle read_req, out_ready=1 -> out_valid high 4 consecutive cycles starting 1 cycle after the request. Beats are (0,5),(1,9),(2,9),(3,2), out_last only on beat 3. Then winner=1, tie=1, winner_valid=1, busy=0.
- Tallies 3,7,1,200; out_ready low for 3 cycles while beat 2 is presented -> out_data=1 and out_cand=2 held stable with out_valid=1 during the stall. Stream completes with winner=3, tie=0.
- Start readout of 10,20,30,40, then change all inputs to 0xFF after beat 0 -> streamed data is still 10,20,30,40, winner=3.
- Drive mode=0 after beat 1 transfers -> out_valid=0 and busy=0 the next cycle, winner_valid=0. read_req with mode=0 -> no response.
- All tallies 0 -> beats all 0, winner=0, tie=1. Tallies 255,255,255,255 -> winner=0, tie=1.
- Assert reset (0) asynchronously mid-stream between clock edges -> all outputs 0 immediately. After release, a new read_req streams correctly from candidate 0.
